fault_event_logger: RTL

FAULT_EVENT_LOGGER -- requirements
Module: fault_event_logger

---
 rtl/pwr_seq_pkg.sv | 32 +++
 rtl/evt_fifo.sv | 74 +++++++
 rtl/fault_event_logger.sv | 111 +++++++++++
 3 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the power-sequencer fault logging path: fault
// source codes, entry field widths and the lowest-pending-source picker.
package pwr_seq_pkg;

  localparam int FLT_N       = 7;
  localparam int CODE_W      = 3;
  localparam int STATE_W     = 4;
  localparam int ENTRY_HDR_W = CODE_W + STATE_W;

  // Fault source codes; the code equals the bit index in the fault flag bus.
  typedef enum logic [CODE_W-1:0] {
    FLT_AUX_SEQPWR   = 3'd0,
    FLT_FAN_SEQPWR   = 3'd1,
    FLT_N1N2_SEQPWR  = 3'd2,
    FLT_PERST_SEQPWR = 3'd3,
    FLT_AUX_RUNTIME  = 3'd4,
    FLT_FAN_RUNTIME  = 3'd5,
    FLT_N1N2_RUNTIME = 3'd6
  } flt_code_e;

  // Index of the lowest set bit; returns code 0 for an empty mask, so the
  // caller must qualify the result with a non-empty check.
  function automatic flt_code_e lowest_set(input logic [FLT_N-1:0] mask);
    flt_code_e idx;
    idx = FLT_AUX_SEQPWR;
    for (int i = FLT_N - 1; i >= 0; i--) begin
      if (mask[i]) idx = flt_code_e'(CODE_W'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event FIFO. Storage is not reset; only the
// pointers, count and valid flag are.
//
// Handshake: o_valid is the "valid" of the head entry and i_pop is the
// consumer's "ready"; an entry leaves only on a cycle where both are 1, and
// o_data holds the head unchanged while o_valid=1 and i_pop=0. On the push
// side i_push is "valid" and o_push_ok reports acceptance: a push is taken
// when the FIFO is not full or a pop happens in the same cycle.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic                     o_push_ok,
  output logic                     o_valid,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_valid;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [PTR_W:0]   w_count_nxt;

  assign w_full = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_pop  = i_pop && r_valid && !i_clr;
  assign w_push = i_push && !i_clr && (!w_full || w_pop);

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
    if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  // Pointer and occupancy registers; clear flushes everything at once.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_push_ok = w_push;
  assign o_valid   = r_valid;
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

endmodule

// File: rtl/fault_event_logger.sv
// Fault event logger: detects falling edges on active-low fault flags,
// serialises them lowest-index first into a timestamped FIFO, and keeps a
// first-fault record, a sticky overflow flag and per-source sticky latches.
module fault_event_logger
  import pwr_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                            iClk,
  input  logic                            iRst_n,
  input  logic                            iTick_1ms,
  input  logic [FLT_N-1:0]                iFlt_N,
  input  logic [STATE_W-1:0]              iFSM_State,
  input  logic                            iRd_Req,
  input  logic                            iClr,
  output logic                            oRd_Valid,
  output logic [ENTRY_HDR_W+TS_W-1:0]     oRd_Data,
  output logic [$clog2(DEPTH):0]          oCount,
  output logic                            oOverflow,
  output logic                            oFirst_Valid,
  output logic [ENTRY_HDR_W-1:0]          oFirst_Flt,
  output logic [FLT_N-1:0]                oFlt_Latched_N,
  output logic                            oFault_Any_N
);

  logic [FLT_N-1:0]       r_flt_prev;
  logic [FLT_N-1:0]       r_pend;
  logic [FLT_N-1:0]       r_latch_n;
  logic [TS_W-1:0]        r_ts;
  logic                   r_overflow;
  logic                   r_first_valid;
  logic [ENTRY_HDR_W-1:0] r_first_flt;

  logic [FLT_N-1:0]       w_edge;
  logic                   w_log;
  flt_code_e              w_code;
  logic [FLT_N-1:0]       w_grant;
  logic                   w_push_ok;
  logic                   w_drop;

  assign w_edge  = r_flt_prev & ~iFlt_N;
  assign w_log   = |r_pend;
  assign w_code  = lowest_set(r_pend);
  assign w_grant = w_log ? (FLT_N'(1) << w_code) : '0;
  assign w_drop  = w_log && !w_push_ok;

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_HDR_W + TS_W)
  ) u_evt_fifo (
    .i_clk     (iClk),
    .i_rst_n   (iRst_n),
    .i_clr     (iClr),
    .i_push    (w_log),
    .i_data    ({w_code, iFSM_State, r_ts}),
    .i_pop     (iRd_Req),
    .o_push_ok (w_push_ok),
    .o_valid   (oRd_Valid),
    .o_data    (oRd_Data),
    .o_count   (oCount)
  );

  // Previous flag sample; keeps tracking through a clear so a flag held low
  // across the clear does not produce a fresh edge afterwards.
  always_ff @(posedge iClk) begin
    if (!iRst_n) r_flt_prev <= '1;
    else         r_flt_prev <= iFlt_N;
  end

  // Pending mask: retire the granted bit, merge new edges.
  always_ff @(posedge iClk) begin
    if (!iRst_n || iClr) r_pend <= '0;
    else                 r_pend <= (r_pend & ~w_grant) | w_edge;
  end

  // Millisecond timestamp, saturating at all-ones.
  always_ff @(posedge iClk) begin
    if (!iRst_n || iClr)                 r_ts <= '0;
    else if (iTick_1ms && (r_ts != '1))  r_ts <= r_ts + 1'b1;
  end

  // Sticky per-source latches and overflow flag; dropped events still latch.
  always_ff @(posedge iClk) begin
    if (!iRst_n || iClr) begin
      r_latch_n  <= '1;
      r_overflow <= 1'b0;
    end else begin
      r_latch_n <= r_latch_n & ~w_grant;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // First-fault record: captured from the first entry actually stored.
  always_ff @(posedge iClk) begin
    if (!iRst_n || iClr) begin
      r_first_valid <= 1'b0;
      r_first_flt   <= '0;
    end else if (w_push_ok && !r_first_valid) begin
      r_first_valid <= 1'b1;
      r_first_flt   <= {w_code, iFSM_State};
    end
  end

  assign oOverflow      = r_overflow;
  assign oFirst_Valid   = r_first_valid;
  assign oFirst_Flt     = r_first_flt;
  assign oFlt_Latched_N = r_latch_n;
  assign oFault_Any_N   = &r_latch_n;

endmodule
